// File: rtl/esm_rand_issue_sel.sv
// Random-issue selector for the ESM buffer: tracks pending ready indices and
// issues one per handshake, chosen by LFSR or lowest-index-first.
module esm_rand_issue_sel #(
  parameter int          BS        = 16,
  parameter int          N_IN      = 2,
  parameter logic [31:0] LFSR_SEED = 32'hACE12468
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_IN-1:0]               in_valid,
  input  logic [N_IN*$clog2(BS)-1:0]    in_index,
  input  logic                          mode,
  input  logic                          sel_ready,
  output logic                          sel_valid,
  output logic [$clog2(BS)-1:0]         sel_index,
  output logic [$clog2(BS):0]           count,
  output logic                          full,
  output logic                          dup_err
);

  localparam int IW = $clog2(BS);
  localparam logic [31:0] LFSR_TAPS = 32'h80200003;

  typedef enum logic {EMPTY, HOLD} state_t;

  state_t        state, state_next;
  logic [BS-1:0] cand;
  logic [IW:0]   count_q;
  logic          full_q;
  logic          dup_q;
  logic [31:0]   lfsr;

  logic          cand_any;
  logic          load;
  logic [IW:0]   pick_k;
  logic [IW:0]   seen;
  logic [IW-1:0] chosen;
  logic [IW-1:0] idx;
  logic [BS-1:0] clr_mask;
  logic [BS-1:0] kept;
  logic [BS-1:0] set_mask;
  logic [BS-1:0] new_bits;
  logic          dup_any;
  logic [IW:0]   new_cnt;
  logic [IW:0]   count_next;

  assign cand_any = |cand;
  assign load     = cand_any && ((state == EMPTY) || sel_ready);

  // count_q is the pre-insert population, so the modulus range is 1..BS whenever cand is non-empty
  always_comb begin
    pick_k = '0;
    if (!mode && (count_q != '0))
      pick_k = (IW+1)'(lfsr[15:0] % 16'(count_q));
  end

  always_comb begin
    seen   = '0;
    chosen = '0;
    for (int i = 0; i < BS; i++) begin
      if (cand[i]) begin
        if (seen == pick_k)
          chosen = IW'(i);
        seen = seen + 1'b1;
      end
    end
  end

  // Inserts are judged against the set after this edge's removal, so insert wins over issue
  always_comb begin
    clr_mask = '0;
    if (load)
      clr_mask[chosen] = 1'b1;
    kept     = cand & ~clr_mask;
    set_mask = '0;
    dup_any  = 1'b0;
    idx      = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (in_valid[i]) begin
        idx = in_index[i*IW +: IW];
        if (kept[idx] || set_mask[idx])
          dup_any = 1'b1;
        set_mask[idx] = 1'b1;
      end
    end
    new_bits = set_mask & ~kept;
    new_cnt  = '0;
    for (int i = 0; i < BS; i++)
      new_cnt = new_cnt + (IW+1)'(new_bits[i]);
    count_next = count_q + new_cnt - {{IW{1'b0}}, load};
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (load) state_next = HOLD;
      HOLD:    if (sel_ready && !cand_any) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= EMPTY;
      cand      <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      dup_q     <= 1'b0;
      sel_index <= '0;
      lfsr      <= LFSR_SEED;
    end else begin
      state   <= state_next;
      cand    <= kept | set_mask;
      count_q <= count_next;
      full_q  <= (count_next == (IW+1)'(BS));
      dup_q   <= dup_any;
      if (load)
        sel_index <= chosen;
      lfsr <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_TAPS : 32'h0);
    end
  end

  assign sel_valid = (state == HOLD);
  assign count     = count_q;
  assign full      = full_q;
  assign dup_err   = dup_q;

endmodule

// File: tb/tb_esm_rand_issue_sel.sv
// Directed bench for esm_rand_issue_sel: ordered issue, hold, duplicates,
// random drain against an LFSR model, and asynchronous reset.
module tb_esm_rand_issue_sel;

  localparam int          BS   = 16;
  localparam int          N_IN = 2;
  localparam int          IW   = 4;
  localparam logic [31:0] SEED = 32'hACE12468;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [N_IN-1:0]   in_valid = '0;
  logic [N_IN*IW-1:0] in_index = '0;
  logic              mode = 1'b1;
  logic              sel_ready = 1'b0;
  logic              sel_valid;
  logic [IW-1:0]     sel_index;
  logic [IW:0]       count;
  logic              full;
  logic              dup_err;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_lfsr = SEED;
  logic [15:0] m_cand;
  logic [15:0] issued;
  int          m_count;
  int          k;
  int          seen;
  int          exp_idx;

  esm_rand_issue_sel #(.BS(BS), .N_IN(N_IN), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_index(in_index),
    .mode(mode), .sel_ready(sel_ready), .sel_valid(sel_valid),
    .sel_index(sel_index), .count(count), .full(full), .dup_err(dup_err)
  );

  always #5 clk = ~clk;

  // Reference LFSR: Galois x^32+x^22+x^2+x+1, steps every clock out of reset
  always @(posedge clk or negedge rst) begin
    if (!rst) m_lfsr <= SEED;
    else      m_lfsr <= {1'b0, m_lfsr[31:1]} ^ (m_lfsr[0] ? 32'h80200003 : 32'h0);
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] v, input logic [3:0] i0, input logic [3:0] i1);
    in_valid = v;
    in_index = {i1, i0};
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #2;
    checkOutput("rst_valid", sel_valid, 0);
    checkOutput("rst_index", sel_index, 0);
    checkOutput("rst_count", count, 0);
    checkOutput("rst_full", full, 0);
    checkOutput("rst_dup", dup_err, 0);
    #10 rst = 1'b1;

    // 1: single insert, lowest mode
    mode = 1'b1; sel_ready = 1'b1;
    applyStimulus(2'b01, 4'd5, 4'd0);
    tick;
    checkOutput("t1_count_ins", count, 1);
    checkOutput("t1_valid_early", sel_valid, 0);
    applyStimulus(2'b00, 4'd0, 4'd0);
    tick;
    checkOutput("t1_valid", sel_valid, 1);
    checkOutput("t1_index", sel_index, 5);
    checkOutput("t1_count", count, 0);
    tick;
    checkOutput("t1_empty", sel_valid, 0);

    // 2: issue order 3, 9, 12
    applyStimulus(2'b11, 4'd3, 4'd9);
    tick;
    checkOutput("t2_count_ins", count, 2);
    applyStimulus(2'b01, 4'd12, 4'd0);
    tick;
    checkOutput("t2_idx0", sel_index, 3);
    checkOutput("t2_count0", count, 2);
    applyStimulus(2'b00, 4'd0, 4'd0);
    tick;
    checkOutput("t2_idx1", sel_index, 9);
    tick;
    checkOutput("t2_idx2", sel_index, 12);
    checkOutput("t2_count2", count, 0);
    tick;
    checkOutput("t2_empty", sel_valid, 0);

    // 3: back-pressure holds the output stable
    sel_ready = 1'b0;
    applyStimulus(2'b01, 4'd7, 4'd0);
    tick;
    applyStimulus(2'b01, 4'd2, 4'd0);
    tick;
    applyStimulus(2'b00, 4'd0, 4'd0);
    for (int c = 0; c < 10; c++) begin
      checkOutput("t3_hold_valid", sel_valid, 1);
      checkOutput("t3_hold_index", sel_index, 7);
      checkOutput("t3_hold_count", count, 1);
      tick;
    end
    sel_ready = 1'b1;
    tick;
    checkOutput("t3_next_index", sel_index, 2);
    checkOutput("t3_next_count", count, 0);
    sel_ready = 1'b0;

    // 4: duplicates, then insert racing its own removal
    applyStimulus(2'b11, 4'd4, 4'd4);
    tick;
    checkOutput("t4_count", count, 1);
    checkOutput("t4_dup", dup_err, 1);
    applyStimulus(2'b00, 4'd0, 4'd0);
    tick;
    checkOutput("t4_dup_clear", dup_err, 0);
    applyStimulus(2'b01, 4'd4, 4'd0);
    tick;
    checkOutput("t4_dup2", dup_err, 1);
    checkOutput("t4_count2", count, 1);
    applyStimulus(2'b00, 4'd0, 4'd0);
    tick;
    checkOutput("t4_dup2_clear", dup_err, 0);
    sel_ready = 1'b1;
    applyStimulus(2'b01, 4'd4, 4'd0);
    tick;
    checkOutput("t4_race_index", sel_index, 4);
    checkOutput("t4_race_count", count, 1);
    checkOutput("t4_race_dup", dup_err, 0);
    applyStimulus(2'b00, 4'd0, 4'd0);
    tick;
    checkOutput("t4_reissue", sel_index, 4);
    checkOutput("t4_reissue_count", count, 0);
    tick;
    checkOutput("t4_empty", sel_valid, 0);

    // 5: fill all slots behind a held index, then random drain
    sel_ready = 1'b0;
    applyStimulus(2'b01, 4'd15, 4'd0);
    tick;
    applyStimulus(2'b00, 4'd0, 4'd0);
    tick;
    checkOutput("t5_held", sel_index, 15);
    mode = 1'b0;
    for (int c = 0; c < 8; c++) begin
      applyStimulus(2'b11, 4'(2*c), 4'(2*c+1));
      tick;
      checkOutput("t5_fill_count", count, 2*(c+1));
    end
    applyStimulus(2'b00, 4'd0, 4'd0);
    checkOutput("t5_full", full, 1);
    m_cand = 16'hFFFF;
    m_count = 16;
    issued = '0;
    sel_ready = 1'b1;
    for (int n = 0; n < 16; n++) begin
      k = int'(m_lfsr[15:0]) % m_count;
      seen = 0;
      exp_idx = 0;
      for (int i = 0; i < 16; i++) begin
        if (m_cand[i]) begin
          if (seen == k) exp_idx = i;
          seen++;
        end
      end
      tick;
      m_cand[exp_idx] = 1'b0;
      m_count--;
      issued[sel_index] = 1'b1;
      checkOutput("t5_drain_index", sel_index, exp_idx);
      checkOutput("t5_drain_count", count, m_count);
      checkOutput("t5_drain_full", full, 0);
    end
    checkOutput("t5_distinct", issued, 16'hFFFF);
    tick;
    checkOutput("t5_empty", sel_valid, 0);

    // 6: asynchronous reset mid-drain
    mode = 1'b1;
    applyStimulus(2'b11, 4'd1, 4'd2);
    tick;
    applyStimulus(2'b11, 4'd3, 4'd4);
    tick;
    applyStimulus(2'b00, 4'd0, 4'd0);
    checkOutput("t6_pre_valid", sel_valid, 1);
    checkOutput("t6_pre_index", sel_index, 1);
    checkOutput("t6_pre_count", count, 3);
    #3 rst = 1'b0;
    #1;
    checkOutput("t6_rst_valid", sel_valid, 0);
    checkOutput("t6_rst_count", count, 0);
    checkOutput("t6_rst_full", full, 0);
    checkOutput("t6_rst_index", sel_index, 0);
    #2 rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick;
      checkOutput("t6_post_valid", sel_valid, 0);
      checkOutput("t6_post_count", count, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
